// File: rtl/voice_param_bank.sv
// Per-voice note parameter bank: captures decoded note-on/off commands and presents
// one voice per scan cycle to the time-multiplexed oscillator/envelope pipeline.
module voice_param_bank #(
  parameter int NUM_VOICES = 16,
  parameter int PTR_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_SPI_flag,
  input  logic             i_SPI_note_status,
  input  logic [7:0]       i_SPI_voice_index,
  input  logic [31:0]      i_SPI_tuning_code,
  input  logic [6:0]       i_SPI_velocity,
  input  logic             i_scan_en,
  output logic             o_valid,
  output logic             o_frame_start,
  output logic [PTR_W-1:0] o_voice_index,
  output logic [31:0]      o_tuning_code,
  output logic [6:0]       o_velocity,
  output logic             o_gate,
  output logic             o_trigger,
  output logic [8:0]       o_active_count,
  output logic [7:0]       o_bad_index_count
);

  localparam logic [8:0]       NUM_VOICES_W = 9'(NUM_VOICES);
  localparam logic [PTR_W-1:0] LAST_VOICE   = PTR_W'(NUM_VOICES - 1);

  logic [31:0]           tuning_mem   [NUM_VOICES];
  logic [6:0]            velocity_mem [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] trigger_q;
  logic [PTR_W-1:0]      ptr_q;

  logic                  cmd_ok;
  logic                  cmd_bad;
  logic [NUM_VOICES-1:0] wr_hit;
  logic [NUM_VOICES-1:0] on_hit;
  logic [NUM_VOICES-1:0] off_hit;
  logic [NUM_VOICES-1:0] scan_hit;
  logic                  wr_gate_old;
  logic [31:0]           rd_tuning;
  logic [6:0]            rd_velocity;
  logic                  rd_gate;
  logic                  rd_trigger;

  assign cmd_ok  = i_SPI_flag && ({1'b0, i_SPI_voice_index} < NUM_VOICES_W);
  assign cmd_bad = i_SPI_flag && !({1'b0, i_SPI_voice_index} < NUM_VOICES_W);

  always_comb begin
    // NOTE: every signal gets a default before the loop, so no path can leave one unassigned and infer a latch.
    wr_hit      = '0;
    scan_hit    = '0;
    rd_tuning   = '0;
    rd_velocity = '0;
    rd_gate     = 1'b0;
    rd_trigger  = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      wr_hit[v]   = cmd_ok && (i_SPI_voice_index == 8'(v));
      scan_hit[v] = i_scan_en && (ptr_q == PTR_W'(v));
      if (ptr_q == PTR_W'(v)) begin
        rd_tuning   = tuning_mem[v];
        rd_velocity = velocity_mem[v];
        rd_gate     = gate_q[v];
        rd_trigger  = trigger_q[v];
      end
    end
  end

  assign on_hit      = wr_hit & {NUM_VOICES{i_SPI_note_status}};
  assign off_hit     = wr_hit & {NUM_VOICES{!i_SPI_note_status}};
  assign wr_gate_old = |(wr_hit & gate_q);

  // NOTE: storage lives in flops rather than RAM, so it is cleared by reset like any other register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        tuning_mem[v]   <= '0;
        velocity_mem[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (on_hit[v]) begin
          tuning_mem[v]   <= i_SPI_tuning_code;
          velocity_mem[v] <= i_SPI_velocity;
        end
      end
    end
  end

  // A note-on landing on the voice being scanned keeps its trigger for the next visit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gate_q    <= '0;
      trigger_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      gate_q    <= (gate_q | on_hit) & ~off_hit;
      trigger_q <= (trigger_q & ~scan_hit) | on_hit;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_active_count    <= '0;
      o_bad_index_count <= '0;
    end else begin
      if (cmd_ok && i_SPI_note_status && !wr_gate_old)
        o_active_count <= o_active_count + 9'd1;
      else if (cmd_ok && !i_SPI_note_status && wr_gate_old)
        o_active_count <= o_active_count - 9'd1;
      if (cmd_bad && (o_bad_index_count != 8'hFF))
        o_bad_index_count <= o_bad_index_count + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q         <= '0;
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
      o_voice_index <= '0;
      o_tuning_code <= '0;
      o_velocity    <= '0;
      o_gate        <= 1'b0;
      o_trigger     <= 1'b0;
    end else if (i_scan_en) begin
      o_valid       <= 1'b1;
      o_frame_start <= (ptr_q == '0);
      o_voice_index <= ptr_q;
      o_tuning_code <= rd_tuning;
      o_velocity    <= rd_velocity;
      o_gate        <= rd_gate;
      o_trigger     <= rd_trigger;
      ptr_q         <= (ptr_q == LAST_VOICE) ? '0 : ptr_q + 1'b1;
    end else begin
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_voice_param_bank.sv
// Randomized and directed bench for voice_param_bank against a per-voice array model.
module tb_voice_param_bank;

  localparam int NV = 16;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_SPI_flag = 1'b0;
  logic        i_SPI_note_status = 1'b0;
  logic [7:0]  i_SPI_voice_index = '0;
  logic [31:0] i_SPI_tuning_code = '0;
  logic [6:0]  i_SPI_velocity = '0;
  logic        i_scan_en = 1'b0;
  logic        o_valid;
  logic        o_frame_start;
  logic [7:0]  o_voice_index;
  logic [31:0] o_tuning_code;
  logic [6:0]  o_velocity;
  logic        o_gate;
  logic        o_trigger;
  logic [8:0]  o_active_count;
  logic [7:0]  o_bad_index_count;

  voice_param_bank #(.NUM_VOICES(NV), .PTR_W(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_SPI_flag(i_SPI_flag), .i_SPI_note_status(i_SPI_note_status),
    .i_SPI_voice_index(i_SPI_voice_index), .i_SPI_tuning_code(i_SPI_tuning_code),
    .i_SPI_velocity(i_SPI_velocity), .i_scan_en(i_scan_en),
    .o_valid(o_valid), .o_frame_start(o_frame_start), .o_voice_index(o_voice_index),
    .o_tuning_code(o_tuning_code), .o_velocity(o_velocity), .o_gate(o_gate),
    .o_trigger(o_trigger), .o_active_count(o_active_count),
    .o_bad_index_count(o_bad_index_count)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: plain per-voice arrays plus the scan position.
  logic [31:0] m_tun  [NV];
  logic [6:0]  m_vel  [NV];
  bit          m_gate [NV];
  bit          m_trig [NV];
  int          m_ptr;
  int          m_bad;

  logic        e_valid, e_fs, e_gate, e_trig;
  logic [7:0]  e_idx;
  logic [31:0] e_tun;
  logic [6:0]  e_vel;
  logic [8:0]  e_active;
  logic [7:0]  e_bad;

  // Last DUT output seen per voice, for directed value checks.
  logic [31:0] seen_tun  [NV];
  logic [6:0]  seen_vel  [NV];
  logic        seen_gate [NV];
  logic        seen_trig [NV];

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_tun[v] = '0; m_vel[v] = '0; m_gate[v] = 0; m_trig[v] = 0;
    end
    m_ptr = 0; m_bad = 0;
    {e_valid, e_fs, e_idx, e_tun, e_vel, e_gate, e_trig, e_active, e_bad} = '0;
  endtask

  task automatic model_edge(bit sc, bit fl, bit on, int idx, logic [31:0] tun, logic [6:0] vel);
    int n;
    if (sc) begin
      e_valid = 1; e_fs = (m_ptr == 0); e_idx = 8'(m_ptr);
      e_tun = m_tun[m_ptr]; e_vel = m_vel[m_ptr];
      e_gate = m_gate[m_ptr]; e_trig = m_trig[m_ptr];
      m_trig[m_ptr] = 0;
      m_ptr = (m_ptr + 1) % NV;
    end else begin
      e_valid = 0; e_fs = 0;
    end
    if (fl) begin
      if (idx >= NV) begin
        if (m_bad < 255) m_bad++;
      end else if (on) begin
        m_tun[idx] = tun; m_vel[idx] = vel; m_gate[idx] = 1; m_trig[idx] = 1;
      end else begin
        m_gate[idx] = 0;
      end
    end
    n = 0;
    for (int v = 0; v < NV; v++) n += m_gate[v];
    e_active = 9'(n);
    e_bad = 8'(m_bad);
  endtask

  // Called at a negedge: drives one cycle, advances the model, compares at the next negedge.
  task automatic run_cycle(bit sc, bit fl, bit on, int idx, logic [31:0] tun, logic [6:0] vel);
    logic [65:0] act, exp;
    i_scan_en = sc; i_SPI_flag = fl; i_SPI_note_status = on;
    i_SPI_voice_index = 8'(idx); i_SPI_tuning_code = tun; i_SPI_velocity = vel;
    @(posedge i_clk);
    model_edge(sc, fl, on, idx, tun, vel);
    @(negedge i_clk);
    i_scan_en = 0; i_SPI_flag = 0;
    act = {o_valid, o_frame_start, o_voice_index, o_tuning_code, o_velocity, o_gate,
           o_trigger, o_active_count, o_bad_index_count};
    exp = {e_valid, e_fs, e_idx, e_tun, e_vel, e_gate, e_trig, e_active, e_bad};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act, exp);
    end
    if (o_valid === 1'b1 && o_voice_index < NV) begin
      seen_tun[o_voice_index]  = o_tuning_code;
      seen_vel[o_voice_index]  = o_velocity;
      seen_gate[o_voice_index] = o_gate;
      seen_trig[o_voice_index] = o_trigger;
    end
  endtask

  task automatic scan_n(int n);
    for (int i = 0; i < n; i++) run_cycle(1, 0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_reset = 1;
    model_reset();
    #2;
    checks++;
    if ({o_valid, o_frame_start, o_voice_index, o_tuning_code, o_velocity, o_gate, o_trigger,
         o_active_count, o_bad_index_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual_valid=%b actual_active=%0d actual_bad=%0d required=all_zero",
               o_valid, o_active_count, o_bad_index_count);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 0;
    @(negedge i_clk);
  endtask

  task automatic test_note_on_frame();
    run_cycle(0, 1, 1, 3, 32'h0001_2345, 7'd100);
    scan_n(NV);
    checks++;
    if ({seen_gate[3], seen_trig[3], seen_tun[3], seen_vel[3]} !== {1'b1, 1'b1, 32'h0001_2345, 7'd100}) begin
      failures++;
      $display("FAIL note_on_v3 actual=%b%b %h %0d required=11 00012345 100",
               seen_gate[3], seen_trig[3], seen_tun[3], seen_vel[3]);
    end
    checks++;
    if (o_active_count !== 9'd1) begin
      failures++;
      $display("FAIL active_after_on actual=%0d required=1", o_active_count);
    end
  endtask

  task automatic test_note_off();
    scan_n(NV);
    checks++;
    if ({seen_gate[3], seen_trig[3]} !== 2'b10) begin
      failures++;
      $display("FAIL second_frame_v3 actual=%b%b required=10", seen_gate[3], seen_trig[3]);
    end
    run_cycle(0, 1, 0, 3, 32'hDEAD_BEEF, 7'd1);
    scan_n(NV);
    checks++;
    if ({seen_gate[3], seen_tun[3], o_active_count} !== {1'b0, 32'h0001_2345, 9'd0}) begin
      failures++;
      $display("FAIL note_off_v3 actual=%b %h %0d required=0 00012345 0",
               seen_gate[3], seen_tun[3], o_active_count);
    end
  endtask

  task automatic test_collision();
    scan_n(5);
    run_cycle(1, 1, 1, 5, 32'h00AB_CDEF, 7'd77);
    checks++;
    if ({o_voice_index, o_gate, o_trigger} !== {8'd5, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL collision_same_edge actual=%0d %b%b required=5 00", o_voice_index, o_gate, o_trigger);
    end
    scan_n(NV);
    checks++;
    if ({seen_gate[5], seen_trig[5], seen_tun[5], seen_vel[5]} !== {1'b1, 1'b1, 32'h00AB_CDEF, 7'd77}) begin
      failures++;
      $display("FAIL collision_next_frame actual=%b%b %h %0d required=11 00abcdef 77",
               seen_gate[5], seen_trig[5], seen_tun[5], seen_vel[5]);
    end
    scan_n(NV - 6);
  endtask

  task automatic test_bad_index();
    run_cycle(0, 1, 1, 16, 32'h1111_1111, 7'd1);
    run_cycle(0, 1, 1, 200, 32'h2222_2222, 7'd2);
    for (int i = 0; i < 300; i++)
      run_cycle(0, 1, $urandom_range(0, 1), $urandom_range(NV, 255), $urandom, 7'($urandom));
    checks++;
    if ({o_bad_index_count, o_active_count} !== {8'd255, 9'd1}) begin
      failures++;
      $display("FAIL bad_index_saturate actual=%0d active=%0d required=255 active=1",
               o_bad_index_count, o_active_count);
    end
    scan_n(NV);
  endtask

  task automatic test_back_to_back();
    test_reset();
    run_cycle(0, 1, 1, 2, 32'h0000_0222, 7'd20);
    run_cycle(0, 1, 1, 2, 32'h0000_0223, 7'd21);
    run_cycle(0, 1, 0, 7, '0, '0);
    checks++;
    if (o_active_count !== 9'd1) begin
      failures++;
      $display("FAIL duplicate_and_idle_off actual=%0d required=1", o_active_count);
    end
    run_cycle(0, 1, 1, 0, 32'h0000_1000, 7'd10);
    run_cycle(0, 1, 1, 1, 32'h0000_1001, 7'd11);
    run_cycle(0, 1, 1, 2, 32'h0000_1002, 7'd12);
    scan_n(NV);
    checks++;
    if ({seen_tun[0], seen_tun[1], seen_tun[2], o_active_count} !==
        {32'h0000_1000, 32'h0000_1001, 32'h0000_1002, 9'd3}) begin
      failures++;
      $display("FAIL back_to_back actual=%h %h %h %0d required=1000 1001 1002 3",
               seen_tun[0], seen_tun[1], seen_tun[2], o_active_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                $urandom_range(0, 19), $urandom, 7'($urandom));
  endtask

  task automatic test_scan_toggle_reset();
    for (int i = 0; i < 40; i++) begin
      if (i == 25) begin
        @(posedge i_clk);
        #3 i_reset = 1;
        model_reset();
        #1;
        checks++;
        if ({o_valid, o_frame_start, o_voice_index, o_gate, o_trigger, o_active_count} !== '0) begin
          failures++;
          $display("FAIL mid_frame_reset actual_valid=%b idx=%0d active=%0d required=all_zero",
                   o_valid, o_voice_index, o_active_count);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 0;
        run_cycle(0, 0, 0, 0, '0, '0);
        run_cycle(1, 0, 0, 0, '0, '0);
        checks++;
        if ({o_valid, o_frame_start, o_voice_index} !== {1'b1, 1'b1, 8'd0}) begin
          failures++;
          $display("FAIL first_after_reset actual=%b%b %0d required=11 0", o_valid, o_frame_start, o_voice_index);
        end
      end
      run_cycle($urandom_range(0, 3) != 0, 0, 0, 0, '0, '0);
    end
  endtask

  initial begin
    model_reset();
    for (int v = 0; v < NV; v++) begin
      seen_tun[v] = 'x; seen_vel[v] = 'x; seen_gate[v] = 'x; seen_trig[v] = 'x;
    end
    test_reset();
    test_note_on_frame();
    test_note_off();
    test_collision();
    test_bad_index();
    test_back_to_back();
    test_random();
    test_scan_toggle_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
